// File: rtl/alu_pkg.sv
// Shared constants, types and helpers for the ALU operand stage and the ALU.
package alu_pkg;

    localparam int unsigned W         = 32;
    localparam int unsigned NREG      = 16;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned ALUOP_W   = 5;

    // ALUop encodings, shared with the ALU
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'b00000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 5'b00001;
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 5'b00010;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 5'b00011;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR = 5'b00100;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL = 5'b00101;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL = 5'b00110;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA = 5'b00111;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT = 5'b01000;

    // Control part of the issue payload handed to the ALU/writeback
    typedef struct packed {
        logic                 alusel;
        logic [ALUOP_W-1:0]   aluop;
        logic [REG_IDX_W-1:0] rd;
        logic                 wen;
    } issue_ctl_t;

    // ALU status flags
    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
    } flags_t;

    // Sign-extend a 16-bit immediate to the datapath width
    function automatic logic [W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two async read ports, one write port, R0 hardwired to zero,
// write-through bypass from the write port to both read ports.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REG = NREG,
    parameter int unsigned DATA_W  = W,
    parameter int unsigned IDX_W   = REG_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_ra_addr,
    output logic [DATA_W-1:0] o_ra_data,
    input  logic [IDX_W-1:0]  i_rb_addr,
    output logic [DATA_W-1:0] o_rb_data,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_mem [NUM_REG];

    // Storage: cleared on reset, writes to R0 dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REG); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read port A with R0 forced to zero and same-cycle write bypass
    always_comb begin
        o_ra_data = '0;
        if (i_ra_addr != '0) begin
            if (i_we && (i_wa == i_ra_addr)) begin
                o_ra_data = i_wd;
            end else begin
                o_ra_data = r_mem[i_ra_addr];
            end
        end
    end

    // Read port B, same behaviour as port A
    always_comb begin
        o_rb_data = '0;
        if (i_rb_addr != '0) begin
            if (i_we && (i_wa == i_rb_addr)) begin
                o_rb_data = i_wd;
            end else begin
                o_rb_data = r_mem[i_rb_addr];
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch / issue stage ahead of the ALU: register file reads, pending
// writeback scoreboard with RAW/WAW stall, issue register and flag register.
module alu_operand_stage #(
    parameter int unsigned NREG = alu_pkg::NREG,
    parameter int unsigned W    = alu_pkg::W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [alu_pkg::REG_IDX_W-1:0] in_rs,
    input  logic [alu_pkg::REG_IDX_W-1:0] in_rt,
    input  logic [alu_pkg::REG_IDX_W-1:0] in_rd,
    input  logic                          in_wen,
    input  logic                          in_use_imm,
    input  logic [alu_pkg::IMM_W-1:0]     in_imm,
    input  logic                          in_alusel,
    input  logic [alu_pkg::ALUOP_W-1:0]   in_aluop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_a,
    output logic [W-1:0]                  out_b,
    output logic                          out_alusel,
    output logic [alu_pkg::ALUOP_W-1:0]   out_aluop,
    output logic [alu_pkg::REG_IDX_W-1:0] out_rd,
    output logic                          out_wen,
    input  logic                          wb_en,
    input  logic [alu_pkg::REG_IDX_W-1:0] wb_rd,
    input  logic [W-1:0]                  wb_data,
    input  logic                          flag_en,
    input  logic                          alu_carry,
    input  logic                          alu_zero,
    input  logic                          alu_sign,
    output logic                          flag_carry,
    output logic                          flag_zero,
    output logic                          flag_sign
);

    import alu_pkg::*;

    logic [W-1:0]    w_rs_data;
    logic [W-1:0]    w_rt_data;
    logic [W-1:0]    w_b;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_busy;
    logic            w_hazard;
    logic            w_accept;

    logic [NREG-1:0] r_pending;
    logic            r_out_valid;
    logic [W-1:0]    r_out_a;
    logic [W-1:0]    r_out_b;
    issue_ctl_t      r_out_ctl;
    flags_t          r_flags;

    regfile_2r1w #(
        .NUM_REG (NREG),
        .DATA_W  (W),
        .IDX_W   (REG_IDX_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_ra_addr (in_rs),
        .o_ra_data (w_rs_data),
        .i_rb_addr (in_rt),
        .o_rb_data (w_rt_data),
        .i_we      (wb_en),
        .i_wa      (wb_rd),
        .i_wd      (wb_data)
    );

    assign w_b = in_use_imm ? W'(sext_imm(in_imm)) : w_rt_data;

    // Scoreboard clear (writeback) and set (accepted writer) vectors; R0 excluded
    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (wb_en && (wb_rd != '0)) begin
            w_clr[wb_rd] = 1'b1;
        end
        if (w_accept && in_wen && (in_rd != '0)) begin
            w_set[in_rd] = 1'b1;
        end
    end

    // A register still blocks unless its writeback lands this very cycle
    assign w_busy   = r_pending & ~w_clr;
    assign w_hazard = w_busy[in_rs]
                    | (w_busy[in_rt] & ~in_use_imm)
                    | (in_wen & w_busy[in_rd]);

    assign in_ready = (~r_out_valid | out_ready) & ~w_hazard;
    assign w_accept = in_valid & in_ready;

    // Pending bits: a same-cycle set overrides a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Issue register: load on accept, drop valid on consume, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_ctl   <= '0;
        end else if (w_accept) begin
            r_out_valid      <= 1'b1;
            r_out_a          <= w_rs_data;
            r_out_b          <= w_b;
            r_out_ctl.alusel <= in_alusel;
            r_out_ctl.aluop  <= in_aluop;
            r_out_ctl.rd     <= in_rd;
            r_out_ctl.wen    <= in_wen;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Flag register captures the ALU status when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (flag_en) begin
            r_flags.carry <= alu_carry;
            r_flags.zero  <= alu_zero;
            r_flags.sign  <= alu_sign;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_alusel = r_out_ctl.alusel;
    assign out_aluop  = r_out_ctl.aluop;
    assign out_rd     = r_out_ctl.rd;
    assign out_wen    = r_out_ctl.wen;
    assign flag_carry = r_flags.carry;
    assign flag_zero  = r_flags.zero;
    assign flag_sign  = r_flags.sign;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs;
    logic [3:0]  in_rt;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic        in_use_imm;
    logic [15:0] in_imm;
    logic        in_alusel;
    logic [4:0]  in_aluop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_alusel;
    logic [4:0]  out_aluop;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flag_en;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_sign;
    logic        flag_carry;
    logic        flag_zero;
    logic        flag_sign;

    int n_cmp;
    int n_err;

    alu_operand_stage #(.NREG(16), .W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .in_alusel  (in_alusel),
        .in_aluop   (in_aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_alusel (out_alusel),
        .out_aluop  (out_aluop),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flag_en    (flag_en),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .flag_sign  (flag_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                         input logic wen, input logic use_imm, input logic [15:0] imm,
                         input logic alusel, input logic [4:0] aluop);
        in_valid   = 1'b1;
        in_rs      = rs;
        in_rt      = rt;
        in_rd      = rd;
        in_wen     = wen;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_alusel  = alusel;
        in_aluop   = aluop;
    endtask

    task automatic writeback(input logic [3:0] rd, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_wen = 1'b0;
        in_use_imm = 1'b0; in_imm = '0; in_alusel = 1'b0; in_aluop = '0;
        out_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        flag_en = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0; alu_sign = 1'b0;

        // Power-on reset
        #2;
        check_eq("por_out_valid", 32'(out_valid), 32'h0);
        check_eq("por_flags", 32'({flag_carry, flag_zero, flag_sign}), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        settle();
        check_eq("por_in_ready", 32'(in_ready), 32'h1);

        // Register operands
        tick();
        writeback(4'd1, 32'hFFFC1FFF);
        tick();
        writeback(4'd2, 32'h00000007);
        tick();
        wb_en = 1'b0;
        issue(4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0, 5'b00001);
        settle();
        check_eq("reg_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check_eq("reg_out_valid", 32'(out_valid), 32'h1);
        check_eq("reg_out_a", out_a, 32'hFFFC1FFF);
        check_eq("reg_out_b", out_b, 32'h00000007);
        check_eq("reg_out_aluop", 32'(out_aluop), 32'h01);
        check_eq("reg_out_alusel", 32'(out_alusel), 32'h0);
        tick();
        check_eq("reg_valid_drop", 32'(out_valid), 32'h0);

        // R0 write ignored, then R0 and immediate operands
        writeback(4'd0, 32'h5);
        tick();
        wb_en = 1'b0;
        issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b1, 5'b00010);
        tick();
        check_eq("r0_out_a", out_a, 32'h0);
        check_eq("r0_out_b", out_b, 32'h0);
        check_eq("r0_out_alusel", 32'(out_alusel), 32'h1);
        issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 16'h8000, 1'b0, 5'b00000);
        tick();
        in_valid = 1'b0;
        check_eq("imm_out_a", out_a, 32'h0);
        check_eq("imm_out_b", out_b, 32'hFFFF8000);

        // RAW stall on rs until writeback of R3
        issue(4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 16'h0, 1'b0, 5'b00000);
        tick();
        check_eq("raw_writer_rd", 32'(out_rd), 32'h3);
        check_eq("raw_writer_wen", 32'(out_wen), 32'h1);
        issue(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0, 5'b00011);
        settle();
        check_eq("raw_stall_0", 32'(in_ready), 32'h0);
        tick();
        check_eq("raw_stall_1", 32'(in_ready), 32'h0);
        check_eq("raw_no_issue", 32'(out_valid), 32'h0);
        writeback(4'd3, 32'h00001234);
        settle();
        check_eq("raw_release", 32'(in_ready), 32'h1);
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        check_eq("raw_out_valid", 32'(out_valid), 32'h1);
        check_eq("raw_out_a", out_a, 32'h00001234);
        check_eq("raw_out_aluop", 32'(out_aluop), 32'h03);
        tick();

        // Backpressure: A held for 3 cycles while B waits, then B and C stream
        issue(4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0, 5'd2);
        tick();
        out_ready = 1'b0;
        issue(4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0, 5'd3);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h0);
            check_eq($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'h1);
            check_eq($sformatf("bp_out_a_%0d", i), out_a, 32'hFFFC1FFF);
            check_eq($sformatf("bp_aluop_%0d", i), 32'(out_aluop), 32'h2);
            tick();
        end
        out_ready = 1'b1;
        settle();
        check_eq("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        check_eq("bp_b_out_a", out_a, 32'h00000007);
        check_eq("bp_b_aluop", 32'(out_aluop), 32'h3);
        issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 16'h0005, 1'b0, 5'd4);
        settle();
        check_eq("bp_c_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_c_valid", 32'(out_valid), 32'h1);
        check_eq("bp_c_out_b", out_b, 32'h00000005);
        check_eq("bp_c_aluop", 32'(out_aluop), 32'h4);
        tick();
        check_eq("bp_drain", 32'(out_valid), 32'h0);

        // Flags capture and hold
        flag_en = 1'b1; alu_carry = 1'b1; alu_zero = 1'b0; alu_sign = 1'b1;
        tick();
        flag_en = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0; alu_sign = 1'b0;
        check_eq("flags_load", 32'({flag_carry, flag_zero, flag_sign}), 32'h5);
        tick(); tick();
        check_eq("flags_hold", 32'({flag_carry, flag_zero, flag_sign}), 32'h5);

        // WAW: second writer of R3 stalls; set wins over same-cycle clear
        issue(4'd1, 4'd0, 4'd3, 1'b1, 1'b1, 16'h0, 1'b0, 5'd0);
        tick();
        issue(4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 16'h0001, 1'b0, 5'd0);
        settle();
        check_eq("waw_stall", 32'(in_ready), 32'h0);
        writeback(4'd3, 32'h55);
        settle();
        check_eq("waw_release", 32'(in_ready), 32'h1);
        tick();
        wb_en = 1'b0;
        check_eq("waw_accept", 32'(out_valid), 32'h1);
        issue(4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 16'h0, 1'b0, 5'd0);
        settle();
        check_eq("waw_set_wins", 32'(in_ready), 32'h0);
        writeback(4'd3, 32'h66);
        settle();
        check_eq("waw_clear", 32'(in_ready), 32'h1);
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        check_eq("waw_out_a", out_a, 32'h66);
        tick();

        // Reset mid-operation
        flag_en = 1'b1; alu_carry = 1'b1; alu_zero = 1'b1; alu_sign = 1'b1;
        out_ready = 1'b0;
        issue(4'd2, 4'd1, 4'd5, 1'b1, 1'b0, 16'h0, 1'b1, 5'd7);
        tick();
        flag_en = 1'b0;
        in_valid = 1'b0;
        check_eq("pre_rst_valid", 32'(out_valid), 32'h1);
        check_eq("pre_rst_flags", 32'({flag_carry, flag_zero, flag_sign}), 32'h7);
        rst_n = 1'b0;
        settle();
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_a", out_a, 32'h0);
        check_eq("rst_out_b", out_b, 32'h0);
        check_eq("rst_out_ctl", 32'({out_alusel, out_aluop, out_rd, out_wen}), 32'h0);
        check_eq("rst_flags", 32'({flag_carry, flag_zero, flag_sign}), 32'h0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        issue(4'd1, 4'd5, 4'd5, 1'b1, 1'b0, 16'h0, 1'b0, 5'd0);
        settle();
        check_eq("post_rst_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check_eq("post_rst_r1", out_a, 32'h0);
        check_eq("post_rst_valid", 32'(out_valid), 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
